// File: rtl/spg_pkg.sv
// rtl/spg_pkg.sv - shared types, default widths and width helpers for serial_pattern_gen
package spg_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_BIT_CYC = 1;
  localparam int DEF_GAP_CYC = 2;

  localparam int DEF_IDX_W   = $clog2(DEF_DATA_W);
  localparam int DEF_BIT_W   = $clog2(DEF_BIT_CYC + 1);
  localparam int DEF_GAP_W   = $clog2(DEF_GAP_CYC + 1);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_pattern_gen_if.sv
// rtl/serial_pattern_gen_if.sv - parallel word handshake into serial_pattern_gen
interface serial_pattern_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] din;
  logic              valid;
  logic              ready;

  modport master (output din, output valid, input ready);
  modport slave  (input din, input valid, output ready);
endinterface

// File: rtl/spg_bit_timer.sv
// rtl/spg_bit_timer.sv - period prescaler; tick marks the last clock of each period of limit+1 clocks
module spg_bit_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == limit);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/serial_pattern_gen.sv
// rtl/serial_pattern_gen.sv - MSB-first serializer with inter-frame gap; SPG_PARITY_EN appends an even-parity bit
module serial_pattern_gen #(
  parameter int DATA_W  = 8,
  parameter int BIT_CYC = 1,
  parameter int GAP_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_pattern_gen_if.slave  s,
  output logic                 x,
  output logic                 busy,
  output logic                 done
);
  import spg_pkg::*;

  localparam int IDX_W  = $clog2(DATA_W);
  localparam int TMR_W  = cnt_w(max2(BIT_CYC, GAP_CYC));
  localparam bit NO_GAP = (GAP_CYC == 0);
  localparam logic [TMR_W-1:0] BIT_LIM = TMR_W'(BIT_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LIM = TMR_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t              state;
  logic [DATA_W-2:0]   sh;
  logic [IDX_W-1:0]    idx;
  logic                ready_r;
`ifdef SPG_PARITY_EN
  logic                par;
`endif

  logic                tick;
  logic                last;
  logic                accept;
  logic [TMR_W-1:0]    tmr_lim;

  assign tmr_lim = (state == GAP) ? GAP_LIM : BIT_LIM;

  spg_bit_timer #(.W(TMR_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (state != IDLE),
    .clr   (accept),
    .limit (tmr_lim),
    .tick  (tick)
  );

  // last: final clock of the final bit period of the frame
  always_comb begin
    last = 1'b0;
`ifdef SPG_PARITY_EN
    if (state == PAR) last = tick;
`else
    if (state == SHIFT) last = tick && (idx == '0);
`endif
  end

  // With no gap, ready opens during the last bit so a held valid chains frames with no idle bit.
  assign s.ready = ready_r | (NO_GAP & last);
  assign accept  = s.valid & s.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sh      <= '0;
      idx     <= '0;
      x       <= 1'b0;
      ready_r <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SPG_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        state   <= SHIFT;
        sh      <= s.din[DATA_W-2:0];
        idx     <= IDX_W'(DATA_W - 1);
        x       <= s.din[DATA_W-1];
        busy    <= 1'b1;
        ready_r <= 1'b0;
        done    <= last;
`ifdef SPG_PARITY_EN
        par     <= ^s.din;
`endif
      end else if (last) begin
        x    <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
        if (NO_GAP) begin
          state   <= IDLE;
          ready_r <= 1'b1;
        end else begin
          state <= GAP;
        end
      end else begin
        case (state)
          IDLE: ;
          SHIFT: begin
            if (tick) begin
`ifdef SPG_PARITY_EN
              if (idx == '0) begin
                state <= PAR;
                x     <= par;
              end else
`endif
              begin
                idx <= idx - IDX_W'(1);
                x   <= sh[DATA_W-2];
                sh  <= sh << 1;
              end
            end
          end
          PAR: ;
          GAP: begin
            if (tick) begin
              state   <= IDLE;
              ready_r <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb/tb_serial_pattern_gen.sv - directed vector bench for serial_pattern_gen over three parameter sets
module tb_serial_pattern_gen;

`ifdef SPG_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk;
  logic rst;
  logic a_x, a_busy, a_done;
  logic b_x, b_busy, b_done;
  logic c_x, c_busy, c_done;

  serial_pattern_gen_if #(.DATA_W(8)) a_if ();
  serial_pattern_gen_if #(.DATA_W(8)) b_if ();
  serial_pattern_gen_if #(.DATA_W(8)) c_if ();

  serial_pattern_gen #(.DATA_W(8), .BIT_CYC(1), .GAP_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .s(a_if.slave), .x(a_x), .busy(a_busy), .done(a_done));
  serial_pattern_gen #(.DATA_W(8), .BIT_CYC(3), .GAP_CYC(2)) dut_b (
    .clk(clk), .rst(rst), .s(b_if.slave), .x(b_x), .busy(b_busy), .done(b_done));
  serial_pattern_gen #(.DATA_W(8), .BIT_CYC(1), .GAP_CYC(0)) dut_c (
    .clk(clk), .rst(rst), .s(c_if.slave), .x(c_x), .busy(c_busy), .done(c_done));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] din;
    logic       x;
    logic       ready;
    logic       busy;
    logic       done;
    string      tag;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic r, input logic v, input logic [7:0] d,
                              input logic ex, input logic er, input logic eb, input logic ed,
                              input string t);
    vec_t e;
    e.rst = r; e.valid = v; e.din = d;
    e.x = ex; e.ready = er; e.busy = eb; e.done = ed; e.tag = t;
    tbl.push_back(e);
  endfunction

  // Full GAP_CYC=2 frame on dut_a; a stray valid with junk data is offered mid-frame.
  function automatic void add_frame(input logic [7:0] w, input logic [7:0] junk);
    add(0, 1, w, w[7], 0, 1, 0, "accept");
    for (int i = 6; i >= 0; i--)
      add(0, (i == 3), junk, w[i], 0, 1, 0, "bit");
    if (P == 1) add(0, 0, 8'h00, ^w, 0, 1, 0, "parity");
    add(0, 0, 8'h00, 0, 0, 0, 1, "gap0");
    add(0, 0, 8'h00, 0, 0, 0, 0, "gap1");
    add(0, 0, 8'h00, 0, 1, 0, 0, "idle");
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] w;
    int         busy_cnt;
    int         l;
    int         f;
    int         pos;
    logic       ex;

    rst = 1'b1;
    a_if.valid = 1'b0; a_if.din = 8'h00;
    b_if.valid = 1'b0; b_if.din = 8'h00;
    c_if.valid = 1'b0; c_if.din = 8'h00;

    add(1, 0, 8'h00, 0, 1, 0, 0, "rst0");
    add(1, 0, 8'h00, 0, 1, 0, 0, "rst1");
    add(0, 0, 8'h00, 0, 1, 0, 0, "idle");
    add_frame(8'hA5, 8'hFF);
    add(0, 1, 8'hAA, 1, 0, 1, 0, "aa_accept");
    add(0, 0, 8'h00, 0, 0, 1, 0, "aa_b6");
    add(0, 0, 8'h00, 1, 0, 1, 0, "aa_b5");
    add(0, 0, 8'h00, 0, 0, 1, 0, "aa_b4");
    add(1, 0, 8'h00, 0, 1, 0, 0, "rst_mid");
    add(1, 1, 8'h55, 0, 1, 0, 0, "rst_valid");
    add(0, 0, 8'h00, 0, 1, 0, 0, "post_rst");
    add_frame(8'h3C, 8'h00);
    add_frame(8'h07, 8'hC3);

    for (int i = 0; i < tbl.size(); i++) begin
      rst        = tbl[i].rst;
      a_if.valid = tbl[i].valid;
      a_if.din   = tbl[i].din;
      step();
      chk($sformatf("a_%s[%0d].x", tbl[i].tag, i), 32'(a_x), 32'(tbl[i].x));
      chk($sformatf("a_%s[%0d].ready", tbl[i].tag, i), 32'(a_if.ready), 32'(tbl[i].ready));
      chk($sformatf("a_%s[%0d].busy", tbl[i].tag, i), 32'(a_busy), 32'(tbl[i].busy));
      chk($sformatf("a_%s[%0d].done", tbl[i].tag, i), 32'(a_done), 32'(tbl[i].done));
    end
    rst = 1'b0;
    a_if.valid = 1'b0;

    chk("b_idle.ready", 32'(b_if.ready), 32'd1);
    chk("b_idle.x", 32'(b_x), 32'd0);
    chk("c_idle.ready", 32'(c_if.ready), 32'd1);
    chk("c_idle.busy", 32'(c_busy), 32'd0);

    // BIT_CYC=3: each bit of 0x0F held three clocks
    b_if.valid = 1'b1;
    b_if.din   = 8'h0F;
    step();
    b_if.valid = 1'b0;
    busy_cnt = 0;
    l = (8 + P) * 3;
    for (int c = 0; c < l; c++) begin
      w = 8'h0F;
      ex = (c < 12) ? 1'b0 : ((c < 24) ? 1'b1 : ^w);
      chk($sformatf("b_x[%0d]", c), 32'(b_x), 32'(ex));
      chk($sformatf("b_done[%0d]", c), 32'(b_done), 32'd0);
      if (b_busy) busy_cnt++;
      step();
    end
    chk("b_end.done", 32'(b_done), 32'd1);
    chk("b_end.busy", 32'(b_busy), 32'd0);
    chk("b_end.x", 32'(b_x), 32'd0);
    chk("b_busy_cycles", 32'(busy_cnt), 32'(l));

    // GAP_CYC=0 with valid held: 0xFF then 0x00 back to back
    c_if.valid = 1'b1;
    c_if.din   = 8'hFF;
    step();
    l = 8 + P;
    for (int c = 0; c <= 2 * l; c++) begin
      f   = c / l;
      pos = c % l;
      w   = (f == 0) ? 8'hFF : 8'h00;
      if (c >= 2 * l) ex = 1'b0;
      else if (pos < 8) ex = w[7 - pos];
      else ex = ^w;
      chk($sformatf("c_x[%0d]", c), 32'(c_x), 32'(ex));
      chk($sformatf("c_done[%0d]", c), 32'(c_done), 32'((c == l) || (c == 2 * l)));
      chk($sformatf("c_busy[%0d]", c), 32'(c_busy), 32'(c < 2 * l));
      chk($sformatf("c_ready[%0d]", c), 32'(c_if.ready), 32'((c == l - 1) || (c >= 2 * l - 1)));
      if (c == 0) c_if.din = 8'h00;
      if (c == l) c_if.valid = 1'b0;
      step();
    end
    chk("c_after.done", 32'(c_done), 32'd0);
    chk("c_after.ready", 32'(c_if.ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
